bitstream_fetch_ctrl: RTL and testbench

Front-end sequencer for the 128-bit bitstream buffer. Accepts the NAL byte stream from the input FIFO, hunts for the first start code, and strips emulation-prevention bytes (0x03 after two zeros). It packs the surviving bytes into 16-bit words and writes them into the buffer under the buffer's `next` flow control. It also owns the bit pointer (`pc`/`pc_reg`) and the fill-level accounting that stalls the syntax parser when fewer than 32 valid bits remain.

---
 rtl/bitstream_fetch_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_bitstream_fetch_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitstream_fetch_ctrl.sv
// bitstream_fetch_ctrl
//   Front-end sequencer for the 128-bit bitstream buffer. Hunts for the first
//   start code in the NAL byte stream, strips emulation-prevention bytes
//   (0x03 after two zeros), packs the surviving bytes into 16-bit words for
//   the buffer, and tracks the parser bit pointer and buffer fill level.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   byte_in/valid/ready   input byte stream handshake
//   flush                 abandon current NAL, return to start-code search
//   next                  buffer accepts a word this cycle
//   buf_we/buf_data       word write request ([15:8] = earlier byte)
//   remove_03_flag        0 none, 1 0x03 dropped before high byte, 2 before low
//   sc_detect             pulse after the 0x01 completing a start code
//   pc_advance/pc_delta   parser consumed pc_delta bits (0..16)
//   pc, pc_reg            bit read pointer and its one-cycle-delayed copy
//   bits_avail            unread valid bits (0..128)
//   parser_stall          bits_avail < 32
//   underflow_err         sticky: parser consumed more bits than available
module bitstream_fetch_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic        flush,
  input  logic        next,
  output logic        buf_we,
  output logic [15:0] buf_data,
  output logic [1:0]  remove_03_flag,
  output logic        sc_detect,
  input  logic        pc_advance,
  input  logic [4:0]  pc_delta,
  output logic [6:0]  pc,
  output logic [6:0]  pc_reg,
  output logic [7:0]  bits_avail,
  output logic        parser_stall,
  output logic        underflow_err
);

  typedef enum logic [1:0] {SEARCH, HI, LO, PUSH} state_t;

  state_t      state_q, state_d;
  logic [1:0]  zcnt_q, zcnt_d;
  logic        pend_hi_q, pend_hi_d;
  logic        pend_lo_q, pend_lo_d;
  logic        buf_we_q, buf_we_d;
  logic [15:0] buf_data_q, buf_data_d;
  logic [1:0]  flag_q, flag_d;
  logic        sc_detect_q, sc_detect_d;
  logic [6:0]  pc_q, pc_d;
  logic [6:0]  pc_reg_q, pc_reg_d;
  logic [7:0]  bits_avail_q, bits_avail_d;
  logic        underflow_q, underflow_d;

  logic        accept;
  logic        emu_byte;
  logic        word_wr;
  logic [8:0]  fill_sum;
  logic [8:0]  fill_sub;
  logic [8:0]  fill_net;

  assign byte_ready = (state_q != PUSH) && reset_n;
  assign accept     = byte_valid && byte_ready;
  assign emu_byte   = (byte_in == 8'h03) && (zcnt_q == 2'd2);
  // The buffer latches whenever buf_we and next coincide, so that is what
  // counts as a write for fill accounting, even under a simultaneous flush.
  assign word_wr    = buf_we_q && next;

  always_comb begin
    state_d      = state_q;
    zcnt_d       = zcnt_q;
    pend_hi_d    = pend_hi_q;
    pend_lo_d    = pend_lo_q;
    buf_we_d     = buf_we_q;
    buf_data_d   = buf_data_q;
    flag_d       = flag_q;
    sc_detect_d  = 1'b0;
    pc_d         = pc_q;
    pc_reg_d     = pc_q;
    bits_avail_d = bits_avail_q;
    underflow_d  = underflow_q;
    fill_sum     = '0;
    fill_sub     = '0;
    fill_net     = '0;

    if (accept) begin
      if (byte_in == 8'h00)
        zcnt_d = (zcnt_q == 2'd2) ? 2'd2 : zcnt_q + 2'd1;
      else
        zcnt_d = '0;

      case (state_q)
        SEARCH: begin
          if (byte_in == 8'h01 && zcnt_q == 2'd2) begin
            sc_detect_d = 1'b1;
            state_d     = HI;
          end
        end
        HI: begin
          if (emu_byte) begin
            pend_hi_d = 1'b1;
          end else begin
            buf_data_d[15:8] = byte_in;
            state_d          = LO;
          end
        end
        LO: begin
          if (emu_byte) begin
            pend_lo_d = 1'b1;
          end else begin
            buf_data_d[7:0] = byte_in;
            state_d         = PUSH;
            buf_we_d        = 1'b1;
            flag_d          = pend_hi_q ? 2'd1 : (pend_lo_q ? 2'd2 : 2'd0);
          end
        end
        default: ;
      endcase
    end

    if (state_q == PUSH && next) begin
      state_d   = HI;
      buf_we_d  = 1'b0;
      flag_d    = '0;
      pend_hi_d = 1'b0;
      pend_lo_d = 1'b0;
    end

    if (flush) begin
      state_d     = SEARCH;
      zcnt_d      = '0;
      pend_hi_d   = 1'b0;
      pend_lo_d   = 1'b0;
      buf_we_d    = 1'b0;
      flag_d      = '0;
      sc_detect_d = 1'b0;
    end

    if (pc_advance)
      pc_d = pc_q + {2'b00, pc_delta};

    // Add the incoming word before subtracting consumption so a same-cycle
    // write can cover an advance that would otherwise underflow.
    fill_sum = {1'b0, bits_avail_q} + (word_wr ? 9'd16 : 9'd0);
    fill_sub = pc_advance ? {4'b0000, pc_delta} : 9'd0;
    if (fill_sub > fill_sum) begin
      bits_avail_d = '0;
      underflow_d  = 1'b1;
    end else begin
      fill_net     = fill_sum - fill_sub;
      bits_avail_d = (fill_net > 9'd128) ? 8'd128 : fill_net[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= SEARCH;
      zcnt_q       <= '0;
      pend_hi_q    <= 1'b0;
      pend_lo_q    <= 1'b0;
      buf_we_q     <= 1'b0;
      buf_data_q   <= '0;
      flag_q       <= '0;
      sc_detect_q  <= 1'b0;
      pc_q         <= '0;
      pc_reg_q     <= '0;
      bits_avail_q <= '0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      zcnt_q       <= zcnt_d;
      pend_hi_q    <= pend_hi_d;
      pend_lo_q    <= pend_lo_d;
      buf_we_q     <= buf_we_d;
      buf_data_q   <= buf_data_d;
      flag_q       <= flag_d;
      sc_detect_q  <= sc_detect_d;
      pc_q         <= pc_d;
      pc_reg_q     <= pc_reg_d;
      bits_avail_q <= bits_avail_d;
      underflow_q  <= underflow_d;
    end
  end

  assign buf_we         = buf_we_q;
  assign buf_data       = buf_data_q;
  assign remove_03_flag = flag_q;
  assign sc_detect      = sc_detect_q;
  assign pc             = pc_q;
  assign pc_reg         = pc_reg_q;
  assign bits_avail     = bits_avail_q;
  assign parser_stall   = bits_avail_q < 8'd32;
  assign underflow_err  = underflow_q;

endmodule

// File: tb/tb_bitstream_fetch_ctrl.sv
module tb_bitstream_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        flush;
  logic        next;
  logic        buf_we;
  logic [15:0] buf_data;
  logic [1:0]  remove_03_flag;
  logic        sc_detect;
  logic        pc_advance;
  logic [4:0]  pc_delta;
  logic [6:0]  pc;
  logic [6:0]  pc_reg;
  logic [7:0]  bits_avail;
  logic        parser_stall;
  logic        underflow_err;

  always #5 clk = ~clk;

  bitstream_fetch_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .flush(flush), .next(next),
    .buf_we(buf_we), .buf_data(buf_data), .remove_03_flag(remove_03_flag),
    .sc_detect(sc_detect),
    .pc_advance(pc_advance), .pc_delta(pc_delta),
    .pc(pc), .pc_reg(pc_reg),
    .bits_avail(bits_avail), .parser_stall(parser_stall),
    .underflow_err(underflow_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int sc_seen  = 0;
  int sc_exp   = 0;
  logic [17:0] exp_q[$];
  logic [17:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples just before each rising edge, when inputs have settled.
  always @(negedge clk) begin
    #4;
    if (reset_n === 1'b1) begin
      if (sc_detect) sc_seen++;
      if (buf_we && next) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got data 0x%0h flag %0d, expected no write",
                   buf_data, remove_03_flag);
        end else begin
          mon_e = exp_q.pop_front();
          check("write_data", {16'h0, buf_data}, {16'h0, mon_e[15:0]});
          check("write_flag", {30'h0, remove_03_flag}, {30'h0, mon_e[17:16]});
        end
      end
    end
  end

  task automatic expect_word(input logic [15:0] d, input logic [1:0] f);
    exp_q.push_back({f, d});
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_timeout: byte_ready stayed 0, expected 1");
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_sc();
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h01);
    sc_exp++;
  endtask

  task automatic wait_writes();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL write_timeout: %0d writes outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic advance(input logic [4:0] d);
    pc_advance = 1'b1;
    pc_delta   = d;
    @(negedge clk);
    pc_advance = 1'b0;
    pc_delta   = '0;
  endtask

  task automatic check_reset();
    check("rst_buf_we", {31'h0, buf_we}, 32'h0);
    check("rst_buf_data", {16'h0, buf_data}, 32'h0);
    check("rst_flag", {30'h0, remove_03_flag}, 32'h0);
    check("rst_sc_detect", {31'h0, sc_detect}, 32'h0);
    check("rst_pc", {25'h0, pc}, 32'h0);
    check("rst_pc_reg", {25'h0, pc_reg}, 32'h0);
    check("rst_bits_avail", {24'h0, bits_avail}, 32'h0);
    check("rst_parser_stall", {31'h0, parser_stall}, 32'h1);
    check("rst_underflow", {31'h0, underflow_err}, 32'h0);
    check("rst_byte_ready", {31'h0, byte_ready}, 32'h0);
  endtask

  initial begin
    reset_n    = 1'b0;
    byte_in    = '0;
    byte_valid = 1'b0;
    flush      = 1'b0;
    next       = 1'b1;
    pc_advance = 1'b0;
    pc_delta   = '0;
    repeat (3) @(negedge clk);
    check_reset();
    reset_n = 1'b1;
    @(negedge clk);

    // Test 1: simple start code and one word
    expect_word(16'hABCD, 2'd0);
    send_sc();
    send_byte(8'hAB);
    send_byte(8'hCD);
    wait_writes();
    check("t1_bits_avail", {24'h0, bits_avail}, 32'd16);
    check("t1_sc_count", sc_seen, sc_exp);

    // Test 2: 0x03 dropped before the high byte
    pulse_flush();
    expect_word(16'h0000, 2'd0);
    expect_word(16'h0155, 2'd1);
    send_sc();
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h01);
    send_byte(8'h55);
    wait_writes();

    // Test 3: 0x03 dropped before the low byte
    pulse_flush();
    expect_word(16'hAA00, 2'd0);
    expect_word(16'h0002, 2'd2);
    send_sc();
    send_byte(8'hAA);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h02);
    wait_writes();
    check("t3_bits_avail", {24'h0, bits_avail}, 32'd80);
    check("t3_sc_count", sc_seen, sc_exp);

    // Test 4: backpressure holds the word in PUSH
    pulse_flush();
    next = 1'b0;
    expect_word(16'h1234, 2'd0);
    send_sc();
    send_byte(8'h12);
    send_byte(8'h34);
    for (int i = 0; i < 4; i++) begin
      check("t4_buf_we", {31'h0, buf_we}, 32'h1);
      check("t4_buf_data", {16'h0, buf_data}, 32'h1234);
      check("t4_flag", {30'h0, remove_03_flag}, 32'h0);
      check("t4_byte_ready", {31'h0, byte_ready}, 32'h0);
      @(negedge clk);
    end
    next = 1'b1;
    wait_writes();
    repeat (4) @(negedge clk);
    check("t4_bits_avail", {24'h0, bits_avail}, 32'd96);

    // Test 6: flush in LO drops the half-packed word
    pulse_flush();
    send_sc();
    send_byte(8'h77);
    pulse_flush();
    check("t6_byte_ready", {31'h0, byte_ready}, 32'h1);
    check("t6_buf_we", {31'h0, buf_we}, 32'h0);
    expect_word(16'h8899, 2'd0);
    send_sc();
    send_byte(8'h88);
    send_byte(8'h99);
    wait_writes();
    check("t6_sc_count", sc_seen, sc_exp);
    check("t6_pc", {25'h0, pc}, 32'd0);
    check("t6_bits_avail", {24'h0, bits_avail}, 32'd112);

    // Asynchronous reset with a partial word latched
    send_byte(8'h5A);
    #2 reset_n = 1'b0;
    #1 check_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Test 5: pointer wrap, fill accounting and underflow
    expect_word(16'h1122, 2'd0);
    send_sc();
    send_byte(8'h11);
    send_byte(8'h22);
    wait_writes();
    check("t5_bits_16", {24'h0, bits_avail}, 32'd16);
    advance(5'd8);
    check("t5_bits_8", {24'h0, bits_avail}, 32'd8);
    check("t5_pc_8", {25'h0, pc}, 32'd8);
    check("t5_no_underflow", {31'h0, underflow_err}, 32'h0);
    advance(5'd16);
    check("t5_bits_clamp", {24'h0, bits_avail}, 32'd0);
    check("t5_underflow", {31'h0, underflow_err}, 32'h1);
    check("t5_stall", {31'h0, parser_stall}, 32'h1);
    check("t5_pc_24", {25'h0, pc}, 32'd24);
    for (int k = 0; k < 6; k++) begin
      expect_word({8'h20 + 8'(2 * k), 8'h21 + 8'(2 * k)}, 2'd0);
      send_byte(8'h20 + 8'(2 * k));
      send_byte(8'h21 + 8'(2 * k));
      wait_writes();
      advance(5'd16);
    end
    check("t5_pc_120", {25'h0, pc}, 32'd120);
    check("t5_bits_0", {24'h0, bits_avail}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      expect_word({8'h40 + 8'(2 * k), 8'h41 + 8'(2 * k)}, 2'd0);
      send_byte(8'h40 + 8'(2 * k));
      send_byte(8'h41 + 8'(2 * k));
      wait_writes();
    end
    check("t5_bits_48", {24'h0, bits_avail}, 32'd48);
    next = 1'b0;
    expect_word(16'h6061, 2'd0);
    send_byte(8'h60);
    send_byte(8'h61);
    next       = 1'b1;
    pc_advance = 1'b1;
    pc_delta   = 5'd12;
    @(negedge clk);
    pc_advance = 1'b0;
    pc_delta   = '0;
    check("t5_pc_wrap", {25'h0, pc}, 32'd4);
    check("t5_bits_52", {24'h0, bits_avail}, 32'd52);
    check("t5_pc_reg_lag", {25'h0, pc_reg}, 32'd120);
    check("t5_stall_off", {31'h0, parser_stall}, 32'h0);
    @(negedge clk);
    check("t5_pc_reg_4", {25'h0, pc_reg}, 32'd4);
    wait_writes();

    repeat (4) @(negedge clk);
    check("end_queue_empty", exp_q.size(), 32'd0);
    check("end_sc_count", sc_seen, sc_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
